// File: rtl/vga_glyph_capture.sv
// VGA receive side: recovers line/column timing from h_sync/v_sync, locks to it,
// and decodes the top-left glyph cell of the active area into a 32-bit word.
module vga_glyph_capture #(
  parameter int unsigned HPIXELS     = 800,
  parameter int unsigned VLINES      = 521,
  parameter int unsigned HBP         = 144,
  parameter int unsigned VBP         = 31,
  parameter int unsigned GLYPH_W     = 4,
  parameter int unsigned GLYPH_H     = 8,
  parameter int unsigned LUMA_THRESH = 96
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        h_sync,
  input  logic        v_sync,
  input  logic [5:0]  red,
  input  logic [5:0]  green,
  input  logic [5:0]  blue,
  output logic [31:0] glyph,
  output logic        glyph_valid,
  output logic        locked,
  output logic        sync_err,
  output logic [10:0] line_len
);

  localparam int unsigned HW = 11;
  localparam int unsigned LW = 10;
  localparam int unsigned IW = $clog2(GLYPH_W * GLYPH_H);

  localparam logic [HW-1:0] H_LEN     = HW'(HPIXELS);
  localparam logic [HW-1:0] H_TIMEOUT = HW'(2 * HPIXELS);
  localparam logic [HW-1:0] H_MAX     = '1;
  localparam logic [HW-1:0] COL_LO    = HW'(HBP);
  localparam logic [HW-1:0] COL_HI    = HW'(HBP + GLYPH_W);
  localparam logic [LW-1:0] LINE_LAST = LW'(VLINES - 1);
  localparam logic [LW-1:0] LINE_MAX  = '1;
  localparam logic [LW-1:0] LINE_LO   = LW'(VBP);
  localparam logic [LW-1:0] LINE_HI   = LW'(VBP + GLYPH_H);
  localparam logic [7:0]    THRESH    = 8'(LUMA_THRESH);

  typedef enum logic [1:0] {SEARCH, CHECK, LOCKED} state_t;

  state_t        state, state_n;
  logic          h_r, v_r, h_prev, v_prev;
  logic [5:0]    red_r, green_r, blue_r;
  logic [HW-1:0] hcnt, hcnt_n, col;
  logic [LW-1:0] line;
  logic          frame_dirty;
  logic [31:0]   shadow;
  logic          h_fall, v_fall, on, in_cell, bad_line, bad_frame;
  logic [7:0]    luma;
  logic [IW-1:0] row_idx, col_idx, bit_idx;
  logic          publish, err;

  // Stage 1: sample the link once; all decoding below uses these copies.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      h_r     <= 1'b0;
      v_r     <= 1'b0;
      h_prev  <= 1'b0;
      v_prev  <= 1'b0;
      red_r   <= '0;
      green_r <= '0;
      blue_r  <= '0;
    end else begin
      h_r     <= h_sync;
      v_r     <= v_sync;
      h_prev  <= h_r;
      v_prev  <= v_r;
      red_r   <= red;
      green_r <= green;
      blue_r  <= blue;
    end
  end

  always_comb begin
    h_fall    = h_prev & ~h_r;
    v_fall    = v_prev & ~v_r;
    col       = h_fall ? '0 : hcnt;
    hcnt_n    = h_fall ? HW'(1) : ((hcnt == H_MAX) ? hcnt : hcnt + HW'(1));
    luma      = 8'(red_r) + 8'(green_r) + 8'(blue_r);
    on        = (luma >= THRESH);
    in_cell   = (line >= LINE_LO) && (line < LINE_HI) && (col >= COL_LO) && (col < COL_HI);
    row_idx   = IW'(line - LINE_LO);
    col_idx   = IW'(col - COL_LO);
    bit_idx   = IW'(row_idx * IW'(GLYPH_W) + col_idx);
    bad_line  = h_fall ? (hcnt != H_LEN) : (hcnt == H_TIMEOUT);
    // A v_sync edge that does not coincide with a line start is itself a bad frame.
    bad_frame = v_fall & (~h_fall | bad_line | frame_dirty | (line != LINE_LAST));
  end

  // Position counters, line measurement and glyph shadow capture.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      hcnt        <= '0;
      line        <= '0;
      line_len    <= '0;
      frame_dirty <= 1'b0;
      shadow      <= '0;
    end else begin
      hcnt        <= hcnt_n;
      frame_dirty <= v_fall ? 1'b0 : (frame_dirty | bad_line);
      if (h_fall) begin
        line_len <= hcnt;
        line     <= v_fall ? '0 : ((line == LINE_MAX) ? line : line + LW'(1));
      end
      if (in_cell) shadow[bit_idx] <= on;
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) state <= SEARCH;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    publish = 1'b0;
    err     = 1'b0;
    case (state)
      SEARCH: if (v_fall) state_n = CHECK;
      CHECK: begin
        if (bad_line | bad_frame) begin
          err = 1'b1;
        end else if (v_fall) begin
          state_n = LOCKED;
          publish = 1'b1;
        end
      end
      LOCKED: begin
        if (bad_line | bad_frame) begin
          err     = 1'b1;
          state_n = SEARCH;
        end else if (v_fall) begin
          publish = 1'b1;
        end
      end
      default: state_n = SEARCH;
    endcase
  end

  // Registered outputs; locked tracks the state being entered so it aligns with publish.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      glyph       <= '0;
      glyph_valid <= 1'b0;
      sync_err    <= 1'b0;
      locked      <= 1'b0;
    end else begin
      glyph_valid <= publish;
      sync_err    <= err;
      locked      <= (state_n == LOCKED);
      if (publish) glyph <= shadow;
    end
  end

endmodule
